bit_serial_add_ctrl: RTL and testbench

//  Sequences a single add1 full-adder cell over N clock cycles to add or subtract
//  two N-bit operands LSB-first. Holds the carry between bits and the operand/result

---
 rtl/bsadd_pkg.sv | 10 +
 rtl/bit_serial_add_ctrl_add1.sv | 16 +
 rtl/bit_serial_add_ctrl.sv | 137 +++++++++++++
 tb/tb_bit_serial_add_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/bsadd_pkg.sv
// Shared constants for the bit-serial adder controller: FSM state codes and default width.
package bsadd_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam int N_DEFAULT = 8;

endpackage

// File: rtl/bit_serial_add_ctrl_add1.sv
// Single-bit full-adder cell (add1), purely combinational; shared by the serial controller.
module add1 (
   input  logic A,
   input  logic B,
   input  logic CI,
   output logic S,
   output logic CO
);

   // Sum and carry of one bit position.
   always_comb begin
      S  = A ^ B ^ CI;
      CO = (A & B) | (A & CI) | (B & CI);
   end

endmodule

// File: rtl/bit_serial_add_ctrl.sv
// Bit-serial add/subtract: one add1 cell walks an N-bit operand pair LSB-first over N cycles,
// then latches SUM/COUT/OVF and pulses DONE for one cycle.
module bit_serial_add_ctrl
   import bsadd_pkg::*;
#(
   parameter int N     = N_DEFAULT,
   parameter int CNT_W = 5
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic         START,
   input  logic         OP_SUB,
   input  logic [N-1:0] A_IN,
   input  logic [N-1:0] B_IN,
   output logic         BUSY,
   output logic         DONE,
   output logic [N-1:0] SUM,
   output logic         COUT,
   output logic         OVF
);

   logic [1:0]       state_q,   state_d;
   logic [CNT_W-1:0] cnt_q,     cnt_d;
   logic [N-1:0]     a_sh_q,    a_sh_d;
   logic [N-1:0]     b_sh_q,    b_sh_d;
   logic [N-1:0]     r_sh_q,    r_sh_d;
   logic             carry_q,   carry_d;
   logic             cin_msb_q, cin_msb_d;
   logic [N-1:0]     sum_q,     sum_d;
   logic             cout_q,    cout_d;
   logic             ovf_q,     ovf_d;

   logic fa_sum_s;
   logic fa_co_s;
   logic accept_s;
   logic last_bit_s;

   add1 u_fa (
      .A  (a_sh_q[0]),
      .B  (b_sh_q[0]),
      .CI (carry_q),
      .S  (fa_sum_s),
      .CO (fa_co_s)
   );

   // Next-state and datapath: load on accept, shift one bit per RUN cycle, latch result on the last bit.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      a_sh_d    = a_sh_q;
      b_sh_d    = b_sh_q;
      r_sh_d    = r_sh_q;
      carry_d   = carry_q;
      cin_msb_d = cin_msb_q;
      sum_d     = sum_q;
      cout_d    = cout_q;
      ovf_d     = ovf_q;

      accept_s   = START && ((state_q == ST_IDLE) || (state_q == ST_DONE));
      last_bit_s = (cnt_q == CNT_W'(N - 1));

      case (state_q)
         ST_IDLE: begin
            if (accept_s) state_d = ST_RUN;
            else          state_d = ST_IDLE;
         end
         ST_RUN: begin
            if (last_bit_s) state_d = ST_DONE;
            else            state_d = ST_RUN;
         end
         ST_DONE: begin
            if (accept_s) state_d = ST_RUN;
            else          state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      if (state_q == ST_RUN) begin
         r_sh_d  = {fa_sum_s, r_sh_q[N-1:1]};
         carry_d = fa_co_s;
         a_sh_d  = {1'b0, a_sh_q[N-1:1]};
         b_sh_d  = {1'b0, b_sh_q[N-1:1]};
         cnt_d   = cnt_q + CNT_W'(1);
         if (last_bit_s) begin
            // Carry into the MSB is the carry held going into this final bit.
            cin_msb_d = carry_q;
            sum_d     = {fa_sum_s, r_sh_q[N-1:1]};
            cout_d    = fa_co_s;
            ovf_d     = cin_msb_d ^ fa_co_s;
         end else begin
            cin_msb_d = cin_msb_q;
         end
      end else if (accept_s) begin
         // Subtraction is A + ~B + 1: invert B and seed the carry with 1.
         a_sh_d  = A_IN;
         b_sh_d  = B_IN ^ {N{OP_SUB}};
         carry_d = OP_SUB;
         cnt_d   = {CNT_W{1'b0}};
      end else begin
         cnt_d = cnt_q;
      end
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q   <= ST_IDLE;
         cnt_q     <= {CNT_W{1'b0}};
         a_sh_q    <= {N{1'b0}};
         b_sh_q    <= {N{1'b0}};
         r_sh_q    <= {N{1'b0}};
         carry_q   <= 1'b0;
         cin_msb_q <= 1'b0;
         sum_q     <= {N{1'b0}};
         cout_q    <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         a_sh_q    <= a_sh_d;
         b_sh_q    <= b_sh_d;
         r_sh_q    <= r_sh_d;
         carry_q   <= carry_d;
         cin_msb_q <= cin_msb_d;
         sum_q     <= sum_d;
         cout_q    <= cout_d;
         ovf_q     <= ovf_d;
      end
   end

   assign BUSY = (state_q == ST_RUN);
   assign DONE = (state_q == ST_DONE);
   assign SUM  = sum_q;
   assign COUT = cout_q;
   assign OVF  = ovf_q;

endmodule

// File: tb/tb_bit_serial_add_ctrl.sv
// Directed bench for bit_serial_add_ctrl (N=8): arithmetic reference model checked every cycle,
// plus literal expectations for each directed scenario.
module tb_bit_serial_add_ctrl;

   localparam int N = 8;

   logic         clk = 1'b0;
   logic         rst, start, op_sub;
   logic [N-1:0] a_in, b_in;
   logic         busy, done, cout, ovf;
   logic [N-1:0] sum;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   bit_serial_add_ctrl #(.N(N), .CNT_W(5)) dut (
      .CLK    (clk),
      .RST    (rst),
      .START  (start),
      .OP_SUB (op_sub),
      .A_IN   (a_in),
      .B_IN   (b_in),
      .BUSY   (busy),
      .DONE   (done),
      .SUM    (sum),
      .COUT   (cout),
      .OVF    (ovf)
   );

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   // Reference result {ovf, cout, sum} from plain integer arithmetic.
   function automatic logic [N+1:0] ref_calc(input logic [N-1:0] a, input logic [N-1:0] b,
                                             input logic sub);
      logic [N:0]   full;
      logic [N-1:0] s;
      logic         c;
      int           r;
      if (sub) begin
         s = a - b;
         c = (a >= b);
         r = int'($signed(a)) - int'($signed(b));
      end else begin
         full = {1'b0, a} + {1'b0, b};
         s    = full[N-1:0];
         c    = full[N];
         r    = int'($signed(a)) + int'($signed(b));
      end
      return {((r > 127) || (r < -128)), c, s};
   endfunction

   // Model: an accepted op keeps BUSY for N cycles, then results update and DONE shows for one cycle.
   logic         m_valid = 1'b0;
   int           m_run_left;
   logic         m_done;
   logic [N+1:0] m_res, m_pend;

   always @(posedge clk) begin
      if (rst) begin
         m_valid    <= 1'b1;
         m_run_left <= 0;
         m_done     <= 1'b0;
         m_res      <= '0;
      end else if (m_valid) begin
         if (m_run_left > 0) begin
            m_run_left <= m_run_left - 1;
            m_done     <= (m_run_left == 1);
            if (m_run_left == 1) m_res <= m_pend;
         end else begin
            m_done <= 1'b0;
            if (start) begin
               m_run_left <= N;
               m_pend     <= ref_calc(a_in, b_in, op_sub);
            end
         end
      end
   end

   always @(negedge clk) begin
      if (m_valid) begin
         chk("cyc_busy", {31'd0, busy}, {31'd0, (m_run_left != 0)});
         chk("cyc_done", {31'd0, done}, {31'd0, m_done});
         chk("cyc_sum",  {24'd0, sum},  {24'd0, m_res[N-1:0]});
         chk("cyc_cout", {31'd0, cout}, {31'd0, m_res[N]});
         chk("cyc_ovf",  {31'd0, ovf},  {31'd0, m_res[N+1]});
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Wait for DONE (bounded); returns cycles after the accept edge and BUSY cycle count.
   task automatic wait_done(output int n, output int busy_cnt);
      n        = 0;
      busy_cnt = busy ? 1 : 0;
      while (!done && n < 20) begin
         tick();
         n++;
         if (busy) busy_cnt++;
      end
      if (!done) begin
         failures++;
         $display("FAIL done_timeout got=0 exp=1");
      end
   endtask

   task automatic run_op(input string name, input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic sub, input logic [N-1:0] e_sum, input logic e_cout,
                         input logic e_ovf);
      int n, bc;
      a_in = a; b_in = b; op_sub = sub; start = 1'b1;
      tick();
      start = 1'b0;
      wait_done(n, bc);
      chk({name, "_lat"},  n, 32'd8);
      chk({name, "_busy"}, bc, 32'd8);
      chk({name, "_sum"},  {24'd0, sum}, {24'd0, e_sum});
      chk({name, "_cout"}, {31'd0, cout}, {31'd0, e_cout});
      chk({name, "_ovf"},  {31'd0, ovf}, {31'd0, e_ovf});
   endtask

   initial begin
      int n, bc, dcount, last_t;
      // 1. Reset with random inputs
      rst = 1'b1; start = 1'($urandom); op_sub = 1'($urandom);
      a_in = 8'($urandom); b_in = 8'($urandom);
      tick();
      start = 1'($urandom); a_in = 8'($urandom);
      tick();
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_sum",  {24'd0, sum},  32'd0);
      chk("rst_cout", {31'd0, cout}, 32'd0);
      chk("rst_ovf",  {31'd0, ovf},  32'd0);
      rst = 1'b0; start = 1'b0;
      tick();

      // 2./3. Basic add and subtract
      run_op("add5a3c", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1);
      tick();
      run_op("sub1020", 8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0);
      tick();
      run_op("sub8001", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);
      tick();

      // 4. Carry-out add with START/A_IN toggled during RUN
      a_in = 8'hFF; b_in = 8'h01; op_sub = 1'b0; start = 1'b1;
      tick();
      for (int i = 0; i < 4; i++) begin
         start = 1'(i % 2);
         a_in  = 8'($urandom);
         tick();
      end
      start = 1'b0;
      wait_done(n, bc);
      chk("ffp01_sum",  {24'd0, sum},  32'h00);
      chk("ffp01_cout", {31'd0, cout}, 32'd1);
      chk("ffp01_ovf",  {31'd0, ovf},  32'd0);
      dcount = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (done) dcount++;
      end
      chk("ffp01_extra_done", dcount, 32'd0);

      // 5. START held high: one op per N+1 cycles, SUM held between completions
      a_in = 8'h01; b_in = 8'h01; op_sub = 1'b0; start = 1'b1;
      dcount = 0; last_t = 0;
      for (int t = 1; t <= 40; t++) begin
         tick();
         if (done) begin
            if (dcount > 0) chk("b2b_interval", t - last_t, 32'd9);
            dcount++;
            last_t = t;
         end
         if (dcount > 0) chk("b2b_sum_held", {24'd0, sum}, 32'h02);
      end
      chk("b2b_done_count", dcount, 32'd4);
      start = 1'b0;
      wait_done(n, bc);
      tick();

      // 6. Reset in the 4th RUN cycle aborts the op
      a_in = 8'h33; b_in = 8'h11; op_sub = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      tick(); tick(); tick();
      chk("abort_busy_before", {31'd0, busy}, 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_done", {31'd0, done}, 32'd0);
      chk("abort_sum",  {24'd0, sum},  32'd0);
      chk("abort_cout", {31'd0, cout}, 32'd0);
      chk("abort_ovf",  {31'd0, ovf},  32'd0);
      dcount = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (done) dcount++;
      end
      chk("abort_no_done", dcount, 32'd0);
      run_op("post_abort", 8'h33, 8'h11, 1'b0, 8'h44, 1'b0, 1'b0);
      tick(); tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule
